// File: rtl/gpsreceiver2_pkg.sv
// gpsreceiver2_pkg
// Shared definitions for the GPS-SDR RX capture controller:
//   - capture FSM state encoding (IDLE / CAPTURE / DONE)
//   - capture mode constants (one-shot / circular)
//   - default geometry of the RX sample buffer
package gpsreceiver2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_CIRCULAR = 1'b1;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_NCHAN  = 2;
  localparam int DEF_DATA_W = 2;

endpackage

// File: rtl/gpsreceiver2_capture_decim.sv
// gpsreceiver2_decim
// Decimation gate for the capture controller: passes the first candidate
// sample after arm, then one of every (r_decim+1) candidates.
// Only instantiated when GPSRX2_DECIM_EN is defined.
// Ports:
//   rxb0_clk   in  capture clock
//   r_reset    in  synchronous active-high reset
//   arm        in  capture is being armed this cycle (phase restarts)
//   cand       in  a sample is offered for capture this cycle
//   r_decim    in  decimation factor minus one
//   gate_open  out current candidate may be accepted
module gpsreceiver2_decim (
  input  logic       rxb0_clk,
  input  logic       r_reset,
  input  logic       arm,
  input  logic       cand,
  input  logic [3:0] r_decim,
  output logic       gate_open
);

  logic [3:0] phase_q, phase_d;

  assign gate_open = (phase_q == 4'd0);

  always_comb begin
    phase_d = phase_q;
    if (arm) begin
      phase_d = 4'd0;
    end else if (cand) begin
      // >= rather than == so a factor lowered mid-pass cannot strand the phase
      phase_d = (phase_q >= r_decim) ? 4'd0 : phase_q + 4'd1;
    end
  end

  always_ff @(posedge rxb0_clk) begin
    if (r_reset) phase_q <= 4'd0;
    else         phase_q <= phase_d;
  end

endmodule

// File: rtl/gpsreceiver2_capture.sv
// gpsreceiver2_capture
// Capture controller for the GPS-SDR receive path. Writes packed
// multi-channel front-end samples into the RX sample buffer in one-shot or
// circular mode with a programmable pass length, and reports progress.
// Optional feature macro: GPSRX2_DECIM_EN (adds r_decim and decimation gate).
// Ports:
//   rxb0_clk, r_reset       clock / synchronous active-high reset
//   r_enable, r_mode        arm level, 0 = one-shot, 1 = circular
//   r_length                samples per pass (0 = full depth), latched on arm
//   sample_valid/data       front-end sample strobe and packed samples
//   r_decim                 keep 1 of r_decim+1 samples (macro only)
//   rxb_we/adr/dat          registered buffer write port
//   rx_count                writes since arm, saturating
//   r_busy/r_done/r_wrapped status
module gpsreceiver2_capture
  import gpsreceiver2_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NCHAN  = DEF_NCHAN,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    rxb0_clk,
  input  logic                    r_reset,
  input  logic                    r_enable,
  input  logic                    r_mode,
  input  logic [ADDR_W-1:0]       r_length,
  input  logic                    sample_valid,
  input  logic [NCHAN*DATA_W-1:0] sample_data,
`ifdef GPSRX2_DECIM_EN
  input  logic [3:0]              r_decim,
`endif
  output logic                    rxb_we,
  output logic [ADDR_W-1:0]       rxb_adr,
  output logic [NCHAN*DATA_W-1:0] rxb_dat,
  output logic [ADDR_W:0]         rx_count,
  output logic                    r_busy,
  output logic                    r_done,
  output logic                    r_wrapped
);

  localparam int SW = NCHAN * DATA_W;

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              wrapped_q, wrapped_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [SW-1:0]     dat_q, dat_d;

  logic              arm, cand, gate_open, accept;
  logic [ADDR_W-1:0] last_adr;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == '1) ? v : v + (ADDR_W + 1)'(1);
  endfunction

  assign arm    = (state_q == ST_IDLE) && r_enable;
  assign cand   = (state_q == ST_CAPTURE) && r_enable && sample_valid;
  assign accept = cand && gate_open;
  // len_q == 0 wraps to all-ones here, i.e. a full-depth pass
  assign last_adr = len_q - ADDR_W'(1);

`ifdef GPSRX2_DECIM_EN
  gpsreceiver2_decim u_decim (
    .rxb0_clk  (rxb0_clk),
    .r_reset   (r_reset),
    .arm       (arm),
    .cand      (cand),
    .r_decim   (r_decim),
    .gate_open (gate_open)
  );
`else
  assign gate_open = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    done_d    = done_q;
    wrapped_d = wrapped_q;
    we_d      = 1'b0;
    adr_d     = adr_q;
    dat_d     = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (r_enable) begin
          state_d   = ST_CAPTURE;
          len_d     = r_length;
          mode_d    = r_mode;
          ptr_d     = '0;
          count_d   = '0;
          done_d    = 1'b0;
          wrapped_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (!r_enable) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          we_d    = 1'b1;
          adr_d   = ptr_q;
          dat_d   = sample_data;
          count_d = sat_inc(count_q);
          if (ptr_q == last_adr) begin
            ptr_d = '0;
            if (mode_q == MODE_ONESHOT) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              wrapped_d = 1'b1;
            end
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!r_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rxb0_clk) begin
    if (r_reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      mode_q    <= MODE_ONESHOT;
      ptr_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
    end
  end

  assign rxb_we    = we_q;
  assign rxb_adr   = adr_q;
  assign rxb_dat   = dat_q;
  assign rx_count  = count_q;
  assign r_busy    = (state_q == ST_CAPTURE);
  assign r_done    = done_q;
  assign r_wrapped = wrapped_q;

endmodule

// File: tb/tb_gpsreceiver2_capture.sv
module tb_gpsreceiver2_capture;

  localparam int A  = 4;
  localparam int NC = 2;
  localparam int DW = 2;
  localparam int SW = NC * DW;
  localparam int CNT_MAX = (1 << (A + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [A-1:0]  len;
  logic          valid;
  logic [SW-1:0] data;
`ifdef GPSRX2_DECIM_EN
  logic [3:0]    decim;
`endif
  logic          rxb_we;
  logic [A-1:0]  rxb_adr;
  logic [SW-1:0] rxb_dat;
  logic [A:0]    rx_count;
  logic          r_busy, r_done, r_wrapped;

  int n_cmp = 0;
  int n_err = 0;
  int n_we  = 0;

  // reference model state
  bit m_cap, m_fin, m_circ, m_we, m_done, m_wrap;
  int m_plen, m_total, m_cnt, m_vseen, m_adr, m_dat;

  always #5 clk = ~clk;

  gpsreceiver2_capture #(.ADDR_W(A), .NCHAN(NC), .DATA_W(DW)) dut (
    .rxb0_clk     (clk),
    .r_reset      (rst),
    .r_enable     (en),
    .r_mode       (mode),
    .r_length     (len),
    .sample_valid (valid),
    .sample_data  (data),
`ifdef GPSRX2_DECIM_EN
    .r_decim      (decim),
`endif
    .rxb_we       (rxb_we),
    .rxb_adr      (rxb_adr),
    .rxb_dat      (rxb_dat),
    .rx_count     (rx_count),
    .r_busy       (r_busy),
    .r_done       (r_done),
    .r_wrapped    (r_wrapped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: write index within the pass is simply the number of
  // writes since arm modulo the pass length.
  task automatic model_step();
    bit keep;
    if (rst) begin
      m_cap = 0; m_fin = 0; m_circ = 0; m_we = 0; m_done = 0; m_wrap = 0;
      m_plen = 0; m_total = 0; m_cnt = 0; m_vseen = 0; m_adr = 0; m_dat = 0;
      return;
    end
    m_we = 0;
    if (!m_cap && !m_fin) begin
      if (en) begin
        m_cap = 1; m_plen = (len == 0) ? (1 << A) : int'(len); m_circ = mode;
        m_total = 0; m_cnt = 0; m_done = 0; m_wrap = 0; m_vseen = 0;
      end
    end else if (m_cap) begin
      if (!en) m_cap = 0;
      else if (valid) begin
`ifdef GPSRX2_DECIM_EN
        keep = (m_vseen % (int'(decim) + 1)) == 0;
`else
        keep = 1;
`endif
        m_vseen++;
        if (keep) begin
          m_we = 1;
          m_adr = m_total % m_plen;
          m_dat = int'(data);
          m_total++;
          m_cnt = (m_total > CNT_MAX) ? CNT_MAX : m_total;
          if (m_total % m_plen == 0) begin
            if (!m_circ) begin m_cap = 0; m_fin = 1; m_done = 1; end
            else m_wrap = 1;
          end
        end
      end
    end else begin
      if (!en) m_fin = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (rxb_we) n_we++;
    check("we",      32'(rxb_we),    32'(m_we));
    if (m_we) begin
      check("adr",   32'(rxb_adr),   32'(m_adr));
      check("dat",   32'(rxb_dat),   32'(m_dat));
    end
    check("count",   32'(rx_count),  32'(m_cnt));
    check("busy",    32'(r_busy),    32'(m_cap));
    check("done",    32'(r_done),    32'(m_done));
    check("wrapped", 32'(r_wrapped), 32'(m_wrap));
  endtask

  task automatic run_samples(input int n);
    valid = 1'b1;
    repeat (n) begin
      data = SW'($urandom);
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic arm(input logic md, input logic [A-1:0] ln);
    en = 1'b1; mode = md; len = ln;
    tick();
  endtask

  task automatic disarm();
    en = 1'b0; valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; len = '0; valid = 1'b0; data = '0;
`ifdef GPSRX2_DECIM_EN
    decim = 4'd0;
`endif
    tick(); tick();
    check("rst_we", 32'(rxb_we), 0);
    check("rst_adr", 32'(rxb_adr), 0);
    check("rst_dat", 32'(rxb_dat), 0);
    check("rst_cnt", 32'(rx_count), 0);
    check("rst_busy", 32'(r_busy), 0);
    rst = 1'b0;
    tick();

    // one-shot, length 4, six samples
    arm(1'b0, A'(4));
    n_we = 0;
    run_samples(6);
    check("os_writes", 32'(n_we), 4);
    check("os_done", 32'(r_done), 1);
    check("os_cnt", 32'(rx_count), 4);
    disarm();

    // circular, length 3, seven samples
    arm(1'b1, A'(3));
    n_we = 0;
    run_samples(2);
    check("circ_nowrap", 32'(r_wrapped), 0);
    run_samples(1);
    check("circ_wrap3", 32'(r_wrapped), 1);
    run_samples(4);
    check("circ_writes", 32'(n_we), 7);
    check("circ_cnt", 32'(rx_count), 7);
    check("circ_done", 32'(r_done), 0);
    check("circ_adr", 32'(rxb_adr), 0);
    disarm();

    // length 0 = full depth, one-shot
    arm(1'b0, A'(0));
    n_we = 0;
    run_samples(18);
    check("full_writes", 32'(n_we), 16);
    check("full_done", 32'(r_done), 1);
    disarm();

    // abort together with the third sample
    arm(1'b0, A'(8));
    n_we = 0;
    run_samples(2);
    en = 1'b0; valid = 1'b1; data = SW'($urandom);
    tick();
    valid = 1'b0;
    check("abort_writes", 32'(n_we), 2);
    check("abort_busy", 32'(r_busy), 0);
    check("abort_done", 32'(r_done), 0);
    check("abort_cnt", 32'(rx_count), 2);
    arm(1'b0, A'(8));
    check("rearm_cnt", 32'(rx_count), 0);
    disarm();

    // reset in the middle of a capture with a sample pending
    arm(1'b1, A'(0));
    run_samples(5);
    rst = 1'b1; valid = 1'b1;
    tick();
    check("mrst_we", 32'(rxb_we), 0);
    check("mrst_adr", 32'(rxb_adr), 0);
    check("mrst_cnt", 32'(rx_count), 0);
    check("mrst_busy", 32'(r_busy), 0);
    rst = 1'b0; valid = 1'b0; en = 1'b0;
    tick();

    // circular full depth long enough to saturate rx_count
    arm(1'b1, A'(0));
    run_samples(CNT_MAX + 6);
    check("sat_cnt", 32'(rx_count), CNT_MAX);
    disarm();

`ifdef GPSRX2_DECIM_EN
    decim = 4'd2;
    arm(1'b1, A'(0));
    n_we = 0;
    run_samples(9);
    check("dec_writes", 32'(n_we), 3);
    disarm();
`endif

    // randomized traffic, including mid-pass length/mode changes
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else rst = 1'b0;
      if (en) begin
        if ($urandom_range(0, 39) == 0) en = 1'b0;
      end else begin
`ifdef GPSRX2_DECIM_EN
        decim = 4'($urandom_range(0, 3));
`endif
        if ($urandom_range(0, 3) == 0) en = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) len = A'($urandom);
      if ($urandom_range(0, 9) == 0) mode = 1'($urandom);
      valid = ($urandom_range(0, 9) < 7);
      data  = SW'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
